seq_detector_param: RTL and testbench

Parametrised Mealy serial pattern detector, successor to the fixed 4-bit "1011" detector. Takes one serial bit per enabled clock and compares it against a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping detection is selectable. A saturating match counter is included. It sits on serial bit streams feeding protocol/frame-sync logic.

---
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// Serial detector bundle: bit stream + config strobe in, Mealy match/count/status out.
// No handshake back-pressure: the detector accepts a bit whenever en is high.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               dout;
  logic               dout_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
  logic               cfg_err;

  modport master (
    output en, din, cfg_load, pattern, pat_len, overlap,
    input  dout, dout_q, match_cnt, cnt_sat, cfg_err
  );

  modport slave (
    input  en, din, cfg_load, pattern, pat_len, overlap,
    output dout, dout_q, match_cnt, cnt_sat, cfg_err
  );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector; dout is Mealy (0 cycles), dout_q 1 cycle later.
// No back-pressure: en=0 freezes history/count, cfg_load pre-empts the bit in that cycle.
module seq_detector_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
  parameter logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4)
) (
  input  logic                clk,
  input  logic                rst,
  seq_detector_param_if.slave sif
);

  typedef struct packed {
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
  } cfg_t;

  cfg_t               cfg_reg;
  // The oldest pattern bit is always din's MAX_LEN-1 predecessor, so one bit less is stored.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [CNT_W-1:0]   match_cnt;
  logic               dout_q;
  logic               cfg_err;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] len_mask;
  logic               pat_hit;
  logic               fill_ok;
  logic               len_ok;
  logic               dout_c;
  logic               cnt_full;
  logic [LEN_W-1:0]   fill_inc;

  assign cand = {hist, sif.din};

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(cfg_reg.len));
    end
  end

  assign pat_hit  = ((cand ^ cfg_reg.pat) & len_mask) == '0;
  // fill >= len-1, written without the subtraction so it cannot underflow.
  assign fill_ok  = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, cfg_reg.len};
  assign len_ok   = (sif.pat_len != '0) && (int'(sif.pat_len) <= MAX_LEN);
  assign dout_c   = rst & sif.en & ~sif.cfg_load & fill_ok & pat_hit;
  assign cnt_full = &match_cnt;
  assign fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_reg.pat <= DEF_PAT;
      cfg_reg.len <= DEF_LEN;
      cfg_reg.ovl <= 1'b1;
      hist        <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      dout_q      <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      dout_q <= dout_c;
      if (sif.cfg_load) begin
        if (len_ok) begin
          cfg_reg.pat <= sif.pattern;
          cfg_reg.len <= sif.pat_len;
          cfg_reg.ovl <= sif.overlap;
          hist        <= '0;
          fill        <= '0;
          match_cnt   <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (sif.en) begin
        hist <= cand[MAX_LEN-2:0];
        if (dout_c && !cfg_reg.ovl) begin
          fill <= '0;
        end else begin
          fill <= fill_inc;
        end
        if (dout_c && !cnt_full) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sif.dout      = dout_c;
  assign sif.dout_q    = dout_q;
  assign sif.match_cnt = match_cnt;
  assign sif.cnt_sat   = cnt_full;
  assign sif.cfg_err   = cfg_err;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed bit strings feed a scoreboard queue; a negedge
// monitor pops one expectation per driven cycle. A 2-bit-counter twin sees the same stimulus.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) sif ();
  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) sif2 ();

  assign sif2.en       = sif.en;
  assign sif2.din      = sif.din;
  assign sif2.cfg_load = sif.cfg_load;
  assign sif2.pattern  = sif.pattern;
  assign sif2.pat_len  = sif.pat_len;
  assign sif2.overlap  = sif.overlap;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .sif (sif2)
  );

  typedef struct {
    logic dout;
    int   cnt;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   exp_cnt   = 0;
  logic exp_err   = 1'b0;
  logic prev_dout = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: dout is sampled before the coming edge; dout_q must echo the previous cycle's dout.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_dout = 1'b0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dout",      sif.dout,       e.dout);
      check("dout_q",    sif.dout_q,     prev_dout);
      check("match_cnt", sif.match_cnt,  e.cnt);
      check("cnt_sat",   sif.cnt_sat,    (e.cnt == 255));
      check("cfg_err",   sif.cfg_err,    e.err);
      check("dout_w2",   sif2.dout,      e.dout);
      check("cnt_w2",    sif2.match_cnt, (e.cnt > 3) ? 3 : e.cnt);
      check("sat_w2",    sif2.cnt_sat,   (e.cnt >= 3));
      prev_dout = e.dout;
    end
  end

  task automatic drive(input logic e, input logic d, input logic c, input logic [7:0] p,
                       input logic [3:0] l, input logic o, input logic exp_d);
    exp_t x;
    sif.en       = e;
    sif.din      = d;
    sif.cfg_load = c;
    sif.pattern  = p;
    sif.pat_len  = l;
    sif.overlap  = o;
    x.dout = exp_d;
    x.cnt  = exp_cnt;
    x.err  = exp_err;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // bits: '0'/'1' = en=1 with that din, '-' = en=0 (din=1). exp: '1' where dout must fire.
  // Config pins carry junk outside cfg_load on purpose.
  task automatic run(input string bits, input string exp);
    logic e;
    logic d;
    logic x;
    for (int i = 0; i < bits.len(); i++) begin
      e = (bits[i] != "-");
      d = (bits[i] != "0");
      x = (exp[i] == "1");
      drive(e, d, 1'b0, 8'hC3, 4'd0, 1'b0, x);
      if (x) exp_cnt++;
    end
  endtask

  // Config strobe always lands together with en=1,din=1 to exercise its priority.
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic ok);
    drive(1'b1, 1'b1, 1'b1, p, l, o, 1'b0);
    if (ok) exp_cnt = 0;
    else    exp_err = 1'b1;
  endtask

  task automatic mid_reset();
    sif.en       = 1'b1;
    sif.din      = 1'b1;
    sif.cfg_load = 1'b0;
    #1;
    check("pre_rst_dout", sif.dout, 1);
    rst = 1'b0;
    #1;
    check("rst_dout",      sif.dout,       0);
    check("rst_dout_q",    sif.dout_q,     0);
    check("rst_match_cnt", sif.match_cnt,  0);
    check("rst_cfg_err",   sif.cfg_err,    0);
    check("rst_cnt_w2",    sif2.match_cnt, 0);
    check("rst_sat_w2",    sif2.cnt_sat,   0);
    sif.en  = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b0;
    sif.en       = 1'b0;
    sif.din      = 1'b0;
    sif.cfg_load = 1'b0;
    sif.pattern  = '0;
    sif.pat_len  = '0;
    sif.overlap  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_dout",      sif.dout,      0);
    check("init_dout_q",    sif.dout_q,    0);
    check("init_match_cnt", sif.match_cnt, 0);
    check("init_cnt_sat",   sif.cnt_sat,   0);
    check("init_cfg_err",   sif.cfg_err,   0);
    rst = 1'b1;

    // Default 1011, overlapping
    run("1011011", "0001001");
    // Non-overlapping 1011
    cfg(8'b0000_1011, 4'd4, 1'b0, 1'b1);
    run("1011011", "0001000");
    run("1",       "0");
    run("011",     "001");
    // 111 overlapping / non-overlapping
    cfg(8'b0000_0111, 4'd3, 1'b1, 1'b1);
    run("111111", "001111");
    cfg(8'b0000_0111, 4'd3, 1'b0, 1'b1);
    run("111111", "001001");
    // Length boundaries: 1 bit non-overlap, full MAX_LEN
    cfg(8'b0000_0001, 4'd1, 1'b0, 1'b1);
    run("1101", "1101");
    cfg(8'b1010_0101, 4'd8, 1'b1, 1'b1);
    run("10100101", "00000001");
    // en gating; upper pattern bits beyond pat_len are don't-care
    cfg(8'hAB, 4'd4, 1'b1, 1'b1);
    run("101---1", "0000001");
    // Illegal lengths keep config, history and count
    cfg(8'hFF, 4'd0, 1'b0, 1'b0);
    cfg(8'hFF, 4'd9, 1'b0, 1'b0);
    run("011", "001");
    // cfg_load swallows the completing bit and clears history
    run("101", "000");
    cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    run("1", "0");
    // Five overlapping matches: twin counter saturates at 3
    cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    run("1011011011011011", "0001001001001001");
    run("01", "00");
    // Async reset with a match pending on the pins
    mid_reset();
    run("1011", "0001");

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
